fmul_rr_sched: RTL and testbench

//  Time-shares one fixed-latency FP multiplier (mul datapath incl. special-case logic) between
//  two FIR tap requesters. Round-robin grant, one issue/cycle max, tag pipeline routes each

---
 rtl/fmul_rr_sched.sv | 161 ++++++++++++++++
 tb/tb_fmul_rr_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency FP multiplier
// between two FIR tap requesters, with drain/halt control.
module fmul_rr_sched #(
  parameter int WIDTH = 32,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_go,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_invalid,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             invalid_stky,
  input  logic             stky_clr,
  input  logic             drain,
  output logic             idle
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAINING,
    HALTED
  } state_t;

  state_t         state;
  logic           ptr;
  logic           gnt0;
  logic           gnt1;
  logic           go_id;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic           tail;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == RUN && !drain) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_go <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      go_id  <= 1'b0;
      ptr    <= 1'b0;
    end else begin
      mul_go <= gnt0 | gnt1;
      go_id  <= gnt1;
      if (gnt0) begin
        mul_a <= req0_a;
        mul_b <= req0_b;
      end else if (gnt1) begin
        mul_a <= req1_a;
        mul_b <= req1_b;
      end
      // pointer only rotates when both sides competed
      if (req0_valid && req1_valid && (gnt0 || gnt1))
        ptr <= ~ptr;
    end
  end

  // tag pipe: tail lines up with mul_result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= mul_go;
      tag_id[0] <= go_id;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign tail       = tag_v[LAT-1];
  assign rsp0_valid = tail & ~tag_id[LAT-1];
  assign rsp1_valid = tail & tag_id[LAT-1];
  assign rsp_result = mul_result;

  assign cnt_nxt = cnt + CW'(mul_go) - CW'(tail);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invalid_stky <= 1'b0;
    end else if (tail && mul_invalid) begin
      invalid_stky <= 1'b1;
    end else if (stky_clr) begin
      invalid_stky <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      idle  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (drain) state <= DRAINING;
        end
        DRAINING: begin
          if (!drain) begin
            state <= RUN;
          end else if (cnt_nxt == '0) begin
            state <= HALTED;
            idle  <= 1'b1;
          end
        end
        HALTED: begin
          if (!drain) begin
            state <= RUN;
            idle  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          idle  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_rr_sched.sv
// Bench for fmul_rr_sched: multiplier stand-in, scoreboard model
// and directed scenarios.
module tb_fmul_rr_sched;

  localparam int W = 32;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic [W-1:0] mul_a, mul_b, mul_result;
  logic         mul_go, mul_invalid;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_result;
  logic         invalid_stky, stky_clr, drain, idle;

  int nchk = 0;
  int nerr = 0;

  fmul_rr_sched #(.WIDTH(W), .LAT(L)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_go(mul_go),
    .mul_result(mul_result), .mul_invalid(mul_invalid),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .invalid_stky(invalid_stky),
    .stky_clr(stky_clr), .drain(drain), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  // truncating FP32 multiply, subnormals flushed
  function automatic logic [31:0] fm(logic [31:0] a, logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0))
      return 32'h7FC00000;
    if ((ea == 8'hFF && eb == 0) || (eb == 8'hFF && ea == 0))
      return 32'hFFC00000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    p = 48'({1'b1, fa}) * 48'({1'b1, fb});
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      e++;
      p = p >> 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], p[45:23]};
  endfunction

  function automatic bit finv(logic [31:0] a, logic [31:0] b);
    return (a[30:23] == 8'hFF && a[22:0] == 0 && b[30:23] == 0) ||
           (b[30:23] == 8'hFF && b[22:0] == 0 && a[30:23] == 0);
  endfunction

  // multiplier stand-in; idle slots flag invalid to expose bad tagging
  logic [W-1:0] mres [1:L];
  logic         minv [1:L];
  initial for (int k = 1; k <= L; k++) begin
    mres[k] = '0;
    minv[k] = 1'b0;
  end
  always @(posedge clk) begin
    mres[1] <= fm(mul_a, mul_b);
    minv[1] <= mul_go ? finv(mul_a, mul_b) : 1'b1;
    for (int k = 2; k <= L; k++) begin
      mres[k] <= mres[k-1];
      minv[k] <= minv[k-1];
    end
  end
  assign mul_result  = mres[L];
  assign mul_invalid = minv[L];

  typedef struct {
    int          id;
    logic [31:0] r;
    bit          inv;
    int          due;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  bit    ptr_m = 0, pdrain = 0, stky_m = 0, idle_m = 0;

  always @(negedge clk) begin
    bit    ok, g0, g1, e0, e1, set;
    item_t it;
    if (reset) begin
      q.delete();
      ptr_m = 0; pdrain = 0; stky_m = 0; idle_m = 0;
      chk("rst_go", mul_go, 0);
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_rsp1", rsp1_valid, 0);
      chk("rst_stky", invalid_stky, 0);
      chk("rst_idle", idle, 0);
    end else begin
      ok = !drain && !pdrain;
      g0 = 0; g1 = 0;
      if (ok) begin
        if (req0_valid && req1_valid) begin
          g0 = !ptr_m; g1 = ptr_m; ptr_m = !ptr_m;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      chk("ready0", req0_ready, g0);
      chk("ready1", req1_ready, g1);
      e0 = 0; e1 = 0; set = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        it = q.pop_front();
        e0 = (it.id == 0);
        e1 = (it.id == 1);
        set = it.inv;
        chk("rsp_result", rsp_result, it.r);
      end
      chk("rsp0", rsp0_valid, e0);
      chk("rsp1", rsp1_valid, e1);
      chk("stky", invalid_stky, stky_m);
      chk("idle", idle, idle_m);
      stky_m = (stky_m && !stky_clr) || set;
      idle_m = drain && pdrain && q.size() == 0;
      if (g0) q.push_back('{0, fm(req0_a, req0_b), finv(req0_a, req0_b), cyc + L + 1});
      if (g1) q.push_back('{1, fm(req1_a, req1_b), finv(req1_a, req1_b), cyc + L + 1});
      pdrain = drain;
    end
    cyc++;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int nrsp;
    reset = 1; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    stky_clr = 0; drain = 0;
    tick(2);
    reset = 0;
    #1;
    chk("init_idle", idle, 0);
    chk("init_go", mul_go, 0);
    chk("init_mul_a", mul_a, 0);

    // single request, 1.0 * 2.0
    tick();
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    #1 chk("t1_ready", req0_ready, 1);
    tick(); req0_valid = 0;
    tick(3);
    #1;
    chk("t1_rsp0", rsp0_valid, 1);
    chk("t1_res", rsp_result, 32'h40000000);

    // sustained conflict: alternating grants
    tick(2);
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1; req0_a = 32'h3F800000 + (i << 23); req0_b = 32'h40000000;
      req1_valid = 1; req1_a = 32'h3F800000 + (i << 23); req1_b = 32'h40800000;
      #1;
      chk("t2_rdy0", req0_ready, (i % 2) == 0);
      chk("t2_rdy1", req1_ready, (i % 2) == 1);
      if (i == 4) chk("t2_res4", rsp_result, 32'h40000000);
      if (i == 5) begin
        chk("t2_rsp1", rsp1_valid, 1);
        chk("t2_res5", rsp_result, 32'h41000000);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick(6);

    // inf * 0 sets sticky until cleared
    req1_valid = 1; req1_a = 32'h7F800000; req1_b = 32'h00000000;
    #1 chk("t3_ready", req1_ready, 1);
    tick(); req1_valid = 0;
    tick(3);
    #1;
    chk("t3_rsp1", rsp1_valid, 1);
    chk("t3_res", rsp_result, 32'hFFC00000);
    tick();
    chk("t3_stky", invalid_stky, 1);
    tick(2);
    chk("t3_hold", invalid_stky, 1);
    stky_clr = 1;
    tick(); stky_clr = 0;
    #1 chk("t3_clr", invalid_stky, 0);

    // clear coinciding with a new invalid product
    tick();
    req0_valid = 1; req0_a = 32'h00000000; req0_b = 32'hFF800000;
    tick(); req0_valid = 0;
    tick(3);
    stky_clr = 1;
    #1 chk("t6_rsp0", rsp0_valid, 1);
    tick(); stky_clr = 0;
    #1 chk("t6_stky", invalid_stky, 1);
    stky_clr = 1;
    tick(); stky_clr = 0;
    tick(2);

    // three in flight, then drain to halt and resume
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_a = 32'h40400000 + (i << 23); req0_b = 32'h3F800000;
      tick();
    end
    drain = 1;
    #1 chk("t4_noready", req0_ready, 0);
    tick(3);
    #1;
    chk("t4_last_rsp", rsp0_valid, 1);
    chk("t4_not_idle", idle, 0);
    tick();
    #1 chk("t4_idle", idle, 1);
    tick(2);
    drain = 0;
    #1;
    chk("t4_still_idle", idle, 1);
    chk("t4_halt_rdy", req0_ready, 0);
    tick();
    #1;
    chk("t4_run", idle, 0);
    chk("t4_rdy", req0_ready, 1);
    tick(); req0_valid = 0;
    tick(6);

    // reset with products in flight
    req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40000000;
    tick(); req0_valid = 0;
    req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h40000000;
    tick(); req1_valid = 0;
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("t5_go", mul_go, 0);
    chk("t5_mul_a", mul_a, 0);
    chk("t5_rsp0", rsp0_valid, 0);
    chk("t5_rsp1", rsp1_valid, 0);
    tick(2);
    reset = 0;
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      #1 nrsp += int'(rsp0_valid) + int'(rsp1_valid);
      tick();
    end
    chk("t5_no_rsp", nrsp, 0);

    // mixed traffic
    for (int i = 0; i < 24; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 32'h3F800000 + ($urandom_range(0, 7) << 23);
      req0_b = 32'h40400000;
      req1_a = 32'h3F800000 + ($urandom_range(0, 7) << 23);
      req1_b = 32'h40A00000;
      drain = (i >= 10 && i < 14);
      tick();
    end
    req0_valid = 0; req1_valid = 0; drain = 0;
    tick(8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
